f1_start_ctrl: RTL and testbench

- Sequencer for the F1-style start-light display.
- Fills N_LIGHTS lamps one per tick, then holds all lamps lit for a random number of ticks, then extinguishes them and pulses done.
- The random hold comes from an external LFSR, which this block drives through lfsr_en; the LFSR runs free while idle and is frozen while a sequence is in progress.
- Sits between the tick/clock-divider stage, the LFSR and the lamp outputs.

---
 rtl/f1_start_ctrl.sv | 93 +++++++++
 tb/tb_f1_start_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: fill lamps per tick, random hold, then out.
// Optional abort input when F1_START_CTRL_ABORT_EN is defined.
module f1_start_ctrl #(
  parameter int N_LIGHTS = 8,
  parameter int RAND_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic [RAND_W-1:0]   rnd,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                done
`ifdef F1_START_CTRL_ABORT_EN
  ,
  input  logic                abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [RAND_W-1:0] cnt;
  logic              abort_i;
  logic              full_next;

`ifdef F1_START_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Lamps become all ones once the shift-in reaches the top bit
  assign full_next = &lights[N_LIGHTS-2:0];

  assign lfsr_en = (state == IDLE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lights <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_i && state != IDLE) begin
        state  <= IDLE;
        lights <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (trigger) begin
              state  <= FILL;
              lights <= {{(N_LIGHTS-1){1'b0}}, 1'b1};
            end
          end
          FILL: begin
            if (tick) begin
              lights <= {lights[N_LIGHTS-2:0], 1'b1};
              if (full_next) begin
                state <= HOLD;
                cnt   <= (rnd == '0) ? {{(RAND_W-1){1'b0}}, 1'b1}
                                     : rnd;
              end
            end
          end
          HOLD: begin
            if (tick) begin
              cnt <= cnt - 1'b1;
              if (cnt == {{(RAND_W-1){1'b0}}, 1'b1}) begin
                state  <= IDLE;
                lights <= '0;
                done   <= 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            lights <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed vector bench for f1_start_ctrl (N_LIGHTS=8, RAND_W=7).
module tb_f1_start_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trigger = 1'b0;
  logic       tick = 1'b0;
  logic [6:0] rnd = '0;
  logic       abort_s = 1'b0;
  logic       lfsr_en;
  logic [7:0] lights;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  f1_start_ctrl #(.N_LIGHTS(8), .RAND_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .tick(tick),
    .rnd(rnd),
    .lfsr_en(lfsr_en),
    .lights(lights),
    .busy(busy),
    .done(done)
`ifdef F1_START_CTRL_ABORT_EN
    ,
    .abort(abort_s)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic       k;
    logic [6:0] rn;
    logic [7:0] l;
    logic       b;
    logic       d;
    logic       e;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, t, k, input logic [6:0] rn,
                     input logic [7:0] l, input logic b, d, e);
    vec_t v;
    v.r = r; v.t = t; v.k = k; v.rn = rn;
    v.l = l; v.b = b; v.d = d; v.e = e;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, t, k, input logic [6:0] rn,
                      input logic ab);
    rst = r; trigger = t; tick = k; rnd = rn; abort_s = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] l,
                     input logic b, d, e);
    checks++;
    if ({lights, busy, done, lfsr_en} !== {l, b, d, e}) begin
      failures++;
      $display("FAIL %s: got lights=%h busy=%b done=%b lfsr_en=%b want lights=%h busy=%b done=%b lfsr_en=%b",
               nm, lights, busy, done, lfsr_en, l, b, d, e);
    end
  endtask

  task automatic fill(input logic [6:0] rn);
    logic [7:0] exp;
    step(0, 1, 0, rn, 0);
    chk("fill_start", 8'h01, 1, 0, 0);
    exp = 8'h01;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, rn, 0);
      exp = {exp[6:0], 1'b1};
      chk("fill_tick", exp, 1, 0, 0);
    end
  endtask

  initial begin
    // Reset, full sequence rnd=5, ignored trigger/tick cases
    add(1, 0, 0, 5, 8'h00, 0, 0, 1);
    add(1, 0, 0, 5, 8'h00, 0, 0, 1);
    add(0, 0, 0, 5, 8'h00, 0, 0, 1);
    add(0, 1, 1, 5, 8'h01, 1, 0, 0);
    add(0, 1, 0, 5, 8'h01, 1, 0, 0);
    add(0, 0, 1, 5, 8'h03, 1, 0, 0);
    add(0, 0, 1, 5, 8'h07, 1, 0, 0);
    add(0, 1, 1, 5, 8'h0f, 1, 0, 0);
    add(0, 0, 1, 5, 8'h1f, 1, 0, 0);
    add(0, 0, 1, 5, 8'h3f, 1, 0, 0);
    add(0, 0, 1, 5, 8'h7f, 1, 0, 0);
    add(0, 0, 1, 5, 8'hff, 1, 0, 0);
    add(0, 0, 1, 5, 8'hff, 1, 0, 0);
    add(0, 1, 1, 5, 8'hff, 1, 0, 0);
    add(0, 0, 1, 5, 8'hff, 1, 0, 0);
    add(0, 0, 1, 5, 8'hff, 1, 0, 0);
    add(0, 1, 0, 5, 8'hff, 1, 0, 0);
    add(0, 0, 1, 5, 8'h00, 0, 1, 1);
    add(0, 0, 0, 5, 8'h00, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].t, vq[i].k, vq[i].rn, 0);
      chk($sformatf("vec%0d", i), vq[i].l, vq[i].b, vq[i].d, vq[i].e);
    end

    // rnd == 0 -> one-tick hold
    fill(7'd0);
    step(0, 0, 1, 7'd0, 0);
    chk("rnd0_off", 8'h00, 0, 1, 1);
    step(0, 0, 0, 7'd0, 0);
    chk("rnd0_after", 8'h00, 0, 0, 1);

    // rnd == 127, with rnd changing mid-hold and a tickless stretch
    fill(7'd127);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 7'd3, 0);
    chk("notick_hold", 8'hff, 1, 0, 0);
    for (int i = 8; i < 134; i++) step(0, 0, 1, 7'd3, 0);
    chk("rnd127_t133", 8'hff, 1, 0, 0);
    step(0, 0, 1, 7'd3, 0);
    chk("rnd127_t134", 8'h00, 0, 1, 1);

    // Reset mid-hold, then a normal run and a back-to-back trigger
    fill(7'd2);
    step(0, 0, 1, 7'd2, 0);
    chk("pre_rst", 8'hff, 1, 0, 0);
    step(1, 0, 1, 7'd2, 0);
    chk("rst_hold", 8'h00, 0, 0, 1);
    fill(7'd2);
    step(0, 0, 1, 7'd2, 0);
    chk("rnd2_t8", 8'hff, 1, 0, 0);
    step(0, 0, 1, 7'd2, 0);
    chk("rnd2_done", 8'h00, 0, 1, 1);
    step(0, 1, 0, 7'd2, 0);
    chk("b2b_start", 8'h01, 1, 0, 0);
    step(1, 0, 0, 7'd2, 0);
    chk("rst_fill", 8'h00, 0, 0, 1);

`ifdef F1_START_CTRL_ABORT_EN
    step(0, 1, 0, 7'd9, 0);
    step(0, 0, 1, 7'd9, 0);
    step(0, 0, 1, 7'd9, 0);
    step(0, 0, 1, 7'd9, 0);
    chk("abort_pre", 8'h0f, 1, 0, 0);
    step(0, 0, 1, 7'd9, 1);
    chk("abort_hit", 8'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 7'd9, 0);
      chk("abort_idle", 8'h00, 0, 0, 1);
    end
    step(0, 0, 0, 7'd9, 1);
    chk("abort_in_idle", 8'h00, 0, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
